// File: rtl/sramx_arbiter.sv
// rtl/sramx_arbiter.sv - instruction/data SRAMx arbiter onto one single-port SRAM
// Optional feature macro: SRAMX_ARB_RR_EN (round-robin instead of fixed data priority)
module sramx_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            i_req,
    input  logic [DW/8-1:0] i_wen,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic            i_addr_ok,
    output logic            i_data_ok,
    output logic [DW-1:0]   i_rdata,

    input  logic            d_req,
    input  logic [DW/8-1:0] d_wen,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_addr_ok,
    output logic            d_data_ok,
    output logic [DW-1:0]   d_rdata,

    output logic            m_en,
    output logic [DW/8-1:0] m_wen,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata
);

    localparam int BW = DW / 8;

    logic          grant_i;
    logic          grant_d;
    logic          prefer_i;
    logic          pend_v_q;
    logic          pend_v_d;
    logic          pend_id_q;
    logic          pend_id_d;
    logic [AW-1:0] vaddr;

`ifdef SRAMX_ARB_RR_EN
    logic rr_last_q;
    logic rr_last_d;

    // rr_last is 1 when data was granted last, so instruction is next in line
    assign prefer_i = rr_last_q;

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant_i || grant_d) begin
            rr_last_d = grant_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    logic [1:0] i_wait_q;
    logic [1:0] i_wait_d;

    assign prefer_i = (i_wait_q == 2'd3);

    always_comb begin
        i_wait_d = i_wait_q;
        if (!i_req || grant_i) begin
            i_wait_d = 2'd0;
        end else if (i_wait_q != 2'd3) begin
            i_wait_d = i_wait_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_wait_q <= 2'd0;
        end else begin
            i_wait_q <= i_wait_d;
        end
    end
`endif

    always_comb begin
        grant_i = resetn && i_req && (!d_req || prefer_i);
        grant_d = resetn && d_req && !grant_i;
    end

    assign vaddr = grant_d ? d_addr : i_addr;

    // kseg0/kseg1 (top nibble 8..B) fold onto physical 0x0/0x1 by clearing bits 31 and 29
    always_comb begin
        m_addr = '0;
        if (grant_i || grant_d) begin
            m_addr = vaddr;
            if (vaddr[AW-1 -: 2] == 2'b10) begin
                m_addr[AW-1 -: 4] = {3'b000, vaddr[AW-4]};
            end
        end
    end

    always_comb begin
        m_en    = grant_i || grant_d;
        m_wen   = grant_d ? d_wen : (grant_i ? i_wen : {BW{1'b0}});
        m_wdata = grant_d ? d_wdata : (grant_i ? i_wdata : {DW{1'b0}});
    end

    assign i_addr_ok = grant_i;
    assign d_addr_ok = grant_d;

    always_comb begin
        pend_v_d  = grant_i || grant_d;
        pend_id_d = grant_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_v_q  <= 1'b0;
            pend_id_q <= 1'b0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
        end
    end

    always_comb begin
        i_data_ok = resetn && pend_v_q && !pend_id_q;
        d_data_ok = resetn && pend_v_q && pend_id_q;
        i_rdata   = i_data_ok ? m_rdata : {DW{1'b0}};
        d_rdata   = d_data_ok ? m_rdata : {DW{1'b0}};
    end

endmodule
